// File: rtl/nested_sum_engine.sv
// Nested-sum accumulator: for i in 1..i_limit-1, for j in 0..i-1, k += (i-j) or (i+j).
// Stops early on k reaching k_cap or on k overflowing W bits (saturates to all-ones).
module nested_sum_engine #(
  parameter int W           = 11,
  parameter int AUTO_START  = 1,
  parameter int I_LIMIT_DEF = 60,
  parameter int K_CAP_DEF   = 2000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] i_limit_in,
  input  logic [W-1:0] k_cap_in,
  output logic [2:0]   state,
  output logic [W-1:0] k,
  output logic [W-1:0] i,
  output logic [W-1:0] j,
  output logic         busy,
  output logic         done,
  output logic         capped,
  output logic         ovf
);

  typedef enum logic [2:0] {
    S_OUTER = 3'd0,
    S_INNER = 3'd1,
    S_STEP  = 3'd2,
    S_DONE  = 3'd3,
    S_IDLE  = 3'd4
  } st_t;

  typedef struct packed {
    logic [W-1:0] i_limit;
    logic [W-1:0] k_cap;
    logic         mode;
  } cfg_t;

  st_t          st, st_n;
  cfg_t         cfg, cfg_n;
  logic [W-1:0] k_n, i_n, j_n;
  logic         cap_n, ovf_n;
  logic         cap_hit;
  // Two guard bits: i+j can already need W+1 bits before k is added.
  logic [W+1:0] inc, sum;

  assign state = st;
  assign busy  = (st == S_OUTER) || (st == S_INNER) || (st == S_STEP);

  always_comb begin
    st_n    = st;
    cfg_n   = cfg;
    k_n     = k;
    i_n     = i;
    j_n     = j;
    cap_n   = capped;
    ovf_n   = ovf;
    inc     = cfg.mode ? ({2'b00, i} + {2'b00, j}) : ({2'b00, i} - {2'b00, j});
    sum     = {2'b00, k} + inc;
    cap_hit = (k >= cfg.k_cap);

    if (busy && cap_hit) begin
      st_n  = S_DONE;
      cap_n = 1'b1;
    end else begin
      case (st)
        S_IDLE, S_DONE: begin
          if (start) begin
            cfg_n.i_limit = i_limit_in;
            cfg_n.k_cap   = k_cap_in;
            cfg_n.mode    = mode;
            k_n   = W'(1);
            i_n   = W'(1);
            j_n   = '0;
            cap_n = 1'b0;
            ovf_n = 1'b0;
            st_n  = S_OUTER;
          end
        end
        S_OUTER: begin
          j_n  = '0;
          st_n = (i < cfg.i_limit) ? S_INNER : S_DONE;
        end
        S_INNER: begin
          if (j < i) begin
            j_n = j + 1'b1;
            if (|sum[W+1:W]) begin
              k_n   = '1;
              ovf_n = 1'b1;
              st_n  = S_DONE;
            end else begin
              k_n = sum[W-1:0];
            end
          end else begin
            st_n = S_STEP;
          end
        end
        S_STEP: begin
          i_n  = i + 1'b1;
          st_n = S_OUTER;
        end
        default: st_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= (AUTO_START != 0) ? S_OUTER : S_IDLE;
      cfg.i_limit   <= W'(I_LIMIT_DEF);
      cfg.k_cap     <= W'(K_CAP_DEF);
      cfg.mode      <= 1'b0;
      k             <= W'(1);
      i             <= W'(1);
      j             <= '0;
      capped        <= 1'b0;
      ovf           <= 1'b0;
      done          <= 1'b0;
    end else begin
      st     <= st_n;
      cfg    <= cfg_n;
      k      <= k_n;
      i      <= i_n;
      j      <= j_n;
      capped <= cap_n;
      ovf    <= ovf_n;
      // Pulse only on the transition into DONE, aligned with the state register.
      done   <= (st_n == S_DONE) && (st != S_DONE);
    end
  end

endmodule

// File: tb/tb_nested_sum_engine.sv
// Bench for nested_sum_engine: reset checks, table of known runs, corner sequences,
// and random configs scored against a loop-based arithmetic model.
module tb_nested_sum_engine;
  localparam int W    = 11;
  localparam int KMAX = (1 << W) - 1;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [W-1:0] i_limit_in = '0, k_cap_in = '0;
  logic [2:0]   state, state0;
  logic [W-1:0] k, i, j, k0, i0, j0;
  logic         busy, done, capped, ovf, busy0, done0, capped0, ovf0;

  int n_pass = 0, n_tot = 0;

  typedef struct packed { int k; int i; int j; bit c; bit o; } res_t;
  typedef struct packed { int lim; int cap; bit md; res_t e; } vec_t;

  nested_sum_engine #(.W(W), .AUTO_START(1), .I_LIMIT_DEF(60), .K_CAP_DEF(2000)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .i_limit_in(i_limit_in),
    .k_cap_in(k_cap_in), .state(state), .k(k), .i(i), .j(j), .busy(busy),
    .done(done), .capped(capped), .ovf(ovf));

  nested_sum_engine #(.W(W), .AUTO_START(0), .I_LIMIT_DEF(60), .K_CAP_DEF(2000)) dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .i_limit_in(i_limit_in),
    .k_cap_in(k_cap_in), .state(state0), .k(k0), .i(i0), .j(j0), .busy(busy0),
    .done(done0), .capped(capped0), .ovf(ovf0));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: walk the nested sums directly; cap is tested before the first
  // addition and after every addition, overflow saturates.
  function automatic res_t model(input int lim, input int cap, input bit md);
    res_t r;
    int   s;
    r = '{k: 1, i: 1, j: 0, c: 1'b0, o: 1'b0};
    if (r.k >= cap) begin r.c = 1'b1; return r; end
    for (int a = 1; a < lim; a++) begin
      for (int b = 0; b < a; b++) begin
        s   = r.k + (md ? a + b : a - b);
        r.i = a;
        r.j = b + 1;
        if (s > KMAX) begin r.k = KMAX; r.o = 1'b1; return r; end
        r.k = s;
        if (r.k >= cap) begin r.c = 1'b1; return r; end
      end
    end
    r.i = (lim > 1) ? lim : 1;
    r.j = 0;
    return r;
  endfunction

  task automatic kick(input int lim, input int cap, input bit md);
    @(negedge clk);
    start = 1'b1; i_limit_in = W'(lim); k_cap_in = W'(cap); mode = md;
    @(negedge clk);
    // Scramble inputs so any failure to hold the latched config shows up.
    start = 1'b0; i_limit_in = W'($urandom); k_cap_in = W'($urandom); mode = ~md;
  endtask

  task automatic wait_done(output int pulses, output bit to);
    int cyc;
    cyc = 0; pulses = 0;
    if (done) pulses++;
    while (state != 3'd3 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (done) pulses++;
    end
    to = (state != 3'd3);
    @(negedge clk);
    if (done) pulses++;
  endtask

  task automatic check_run(input string tag, input res_t e);
    int p;
    bit to;
    wait_done(p, to);
    chk({tag, " timeout"}, int'(to), 0);
    chk({tag, " state"}, int'(state), 3);
    chk({tag, " k"}, int'(k), e.k);
    chk({tag, " i"}, int'(i), e.i);
    chk({tag, " j"}, int'(j), e.j);
    chk({tag, " capped"}, int'(capped), int'(e.c));
    chk({tag, " ovf"}, int'(ovf), int'(e.o));
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done pulses"}, p, 1);
  endtask

  initial begin
    vec_t tbl[10];
    res_t e;
    int   cnt, lim, cap, pul;
    bit   md;

    tbl[0] = '{lim: 3,  cap: 2047, md: 1'b0, e: '{k: 5,    i: 3,  j: 0,  c: 1'b0, o: 1'b0}};
    tbl[1] = '{lim: 3,  cap: 2047, md: 1'b1, e: '{k: 7,    i: 3,  j: 0,  c: 1'b0, o: 1'b0}};
    tbl[2] = '{lim: 60, cap: 2047, md: 1'b0, e: '{k: 2047, i: 23, j: 1,  c: 1'b0, o: 1'b1}};
    tbl[3] = '{lim: 1,  cap: 2047, md: 1'b0, e: '{k: 1,    i: 1,  j: 0,  c: 1'b0, o: 1'b0}};
    tbl[4] = '{lim: 60, cap: 1,    md: 1'b0, e: '{k: 1,    i: 1,  j: 0,  c: 1'b1, o: 1'b0}};
    tbl[5] = '{lim: 0,  cap: 2047, md: 1'b1, e: '{k: 1,    i: 1,  j: 0,  c: 1'b0, o: 1'b0}};
    tbl[6] = '{lim: 60, cap: 2000, md: 1'b0, e: '{k: 2004, i: 22, j: 16, c: 1'b1, o: 1'b0}};
    tbl[7] = '{lim: 4,  cap: 2047, md: 1'b0, e: '{k: 11,   i: 4,  j: 0,  c: 1'b0, o: 1'b0}};
    tbl[8] = '{lim: 5,  cap: 12,   md: 1'b0, e: '{k: 15,   i: 4,  j: 1,  c: 1'b1, o: 1'b0}};
    tbl[9] = '{lim: 4,  cap: 2047, md: 1'b1, e: '{k: 19,   i: 4,  j: 0,  c: 1'b0, o: 1'b0}};

    // Reset state of both flavours
    repeat (2) @(negedge clk);
    chk("rst state", int'(state), 0);
    chk("rst k", int'(k), 1);
    chk("rst i", int'(i), 1);
    chk("rst j", int'(j), 0);
    chk("rst flags", int'({capped, ovf, done}), 0);
    chk("rst busy", int'(busy), 1);
    chk("rst0 state", int'(state0), 4);
    chk("rst0 busy", int'(busy0), 0);
    chk("rst0 k", int'(k0), 1);
    chk("rst0 ij", int'({i0, j0}), 1 << W);
    chk("rst0 flags", int'({capped0, ovf0, done0}), 0);

    // Auto-start run with default config
    rst = 1'b0;
    check_run("auto", '{k: 2004, i: 22, j: 16, c: 1'b1, o: 1'b0});

    for (int n = 0; n < 10; n++) begin
      kick(tbl[n].lim, tbl[n].cap, tbl[n].md);
      check_run($sformatf("tbl%0d", n), tbl[n].e);
    end

    // i_limit=1 reaches DONE on the second edge after start
    @(negedge clk);
    start = 1'b1; i_limit_in = W'(1); k_cap_in = W'(2047); mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("lim1 c1 state", int'(state), 0);
    chk("lim1 c1 busy", int'(busy), 1);
    @(negedge clk);
    chk("lim1 c2 state", int'(state), 3);
    chk("lim1 c2 done", int'(done), 1);
    chk("lim1 c2 k", int'(k), 1);
    chk("lim1 c2 capped", int'(capped), 0);
    @(negedge clk);
    chk("lim1 c3 done", int'(done), 0);
    chk("lim1 c3 state", int'(state), 3);

    // Reset mid-run inside INNER aborts without a done pulse
    kick(60, 2047, 1'b0);
    cnt = 0; pul = 0;
    while (!(state == 3'd1 && k > 1) && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (done) pul++;
    end
    chk("midrun reached inner", int'(state == 3'd1 && k > 1), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun rst state", int'(state), 0);
    chk("midrun rst k", int'(k), 1);
    chk("midrun rst ij", int'({i, j}), 1 << W);
    chk("midrun rst flags", int'({capped, ovf, done}), 0);
    chk("midrun no done", pul, 0);

    // Start while busy is ignored: the default run keeps going to its normal end
    cnt = 0;
    while (i < 3 && cnt < 200) begin @(negedge clk); cnt++; end
    chk("busy reach i3", int'(i >= 3), 1);
    start = 1'b1; i_limit_in = W'(3); k_cap_in = W'(2047); mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy start i kept", int'(i >= 3), 1);
    chk("busy start busy", int'(busy), 1);
    check_run("busy start", '{k: 2004, i: 22, j: 16, c: 1'b1, o: 1'b0});

    // Random configs against the model
    for (int n = 0; n < 30; n++) begin
      lim = $urandom_range(0, 40);
      cap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 2047);
      md  = 1'($urandom_range(0, 1));
      e   = model(lim, cap, md);
      kick(lim, cap, md);
      check_run($sformatf("rnd%0d lim=%0d cap=%0d md=%0d", n, lim, cap, md), e);
      if (!e.c && !e.o && !md)
        chk("closed form", int'(k), 1 + (int'(i) - 1) * int'(i) * (int'(i) + 1) / 6);
    end

    // Reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1; start = 1'b1; i_limit_in = W'(3); k_cap_in = W'(2047);
    @(negedge clk);
    chk("prio state", int'(state), 0);
    chk("prio k", int'(k), 1);
    chk("prio state0", int'(state0), 4);
    rst = 1'b0; start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
